// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter sharing one fifo write port
module fifo_wr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       ack,
  input  logic                   fifo_full,
  output logic                   fifo_shift_in,
  output logic [WIDTH-1:0]       fifo_in,
  output logic                   grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [BW-1:0]  bcnt;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic           owner_req;
  logic           xfer;
  logic           last_beat;
  logic           release_grant;
  logic [IDW-1:0] ptr_next;

  // First requester at or after ptr, wrapping modulo N_REQ (explicit for non power-of-2 N_REQ).
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  assign owner_req     = req[grant_id];
  assign xfer          = (state == GRANT) && owner_req && !fifo_full;
  assign last_beat     = (bcnt == BW'(MAX_BURST - 1));
  assign release_grant = (state == GRANT) && ((xfer && last_beat) || !owner_req);
  assign ptr_next      = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

  assign fifo_shift_in = xfer;
  assign fifo_in       = xfer ? data_in[int'(grant_id)*WIDTH +: WIDTH] : '0;
  assign ack           = xfer ? (N_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= IDLE;
      ptr         <= '0;
      bcnt        <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            bcnt        <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_grant) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            ptr         <= ptr_next;
            bcnt        <= '0;
          end else if (xfer) begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
